// File: rtl/preamble_tx_pkg.sv
// Shared definitions for the preamble transmitter and its matched-filter
// receiver: code length limit, config register select codes, state encoding.
package preamble_tx_pkg;
  localparam int MAX_LEN  = 192;   // symbols, 2 code bits each
  localparam int CO_WORDS = 12;    // 32-bit code words
  localparam int CO_BITS  = 384;   // CO_WORDS * 32

  localparam logic [3:0] CS_LEN   = 4'd1;
  localparam logic [3:0] CS_AMP   = 4'd2;
  localparam logic [3:0] CS_CO_HI = 4'd3;   // co[383:352]
  localparam logic [3:0] CS_CO_LO = 4'd13;  // co[63:32]

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Code word slot for a register select: 3 -> word 11 ... 13 -> word 1,
  // every unmapped select lands on word 0 (co[31:0]).
  function automatic logic [3:0] co_word(input logic [3:0] cs);
    if (cs >= CS_CO_HI && cs <= CS_CO_LO) return 4'd14 - cs;
    return 4'd0;
  endfunction
endpackage

// File: rtl/preamble_tx_if.sv
// Preamble transmitter bus: config writes, start/strobe controls and the
// sample/status outputs. master = driver side, slave = preamble_tx.
interface preamble_tx_if;
  logic [31:0] cdata;
  logic [3:0]  cstate;
  logic        cwrite;
  logic        start;
  logic        txstrobe;
  logic [15:0] r_output;
  logic [15:0] i_output;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [15:0] debugbus;

  modport master (
    output cdata, cstate, cwrite, start, txstrobe,
    input  r_output, i_output, tx_valid, busy, done, debugbus
  );
  modport slave (
    input  cdata, cstate, cwrite, start, txstrobe,
    output r_output, i_output, tx_valid, busy, done, debugbus
  );
endinterface

// File: rtl/preamble_tx_code_cfg_regs.sv
// code_cfg_regs: code/amplitude/length config bank shared by transmitter and
// matched-filter receiver.
//   clk, reset : clock, async active-high reset
//   we         : qualified write strobe (caller drops writes it must ignore)
//   cstate     : register select, cdata : write data
//   co_length  : configured code length, amp : amplitude magnitude
//   co         : 384-bit code, symbol k uses co[2k+1:2k]
module code_cfg_regs
  import preamble_tx_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [3:0]         cstate,
  input  logic [31:0]        cdata,
  output logic [7:0]         co_length,
  output logic [14:0]        amp,
  output logic [CO_BITS-1:0] co
);
  logic [CO_WORDS-1:0][31:0] words;

  assign co = words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      co_length <= 8'd192;
      amp       <= 15'h1000;
      words     <= '0;
    end else if (we) begin
      case (cstate)
        CS_LEN:  co_length <= cdata[7:0];
        CS_AMP:  amp       <= cdata[14:0];
        default: words[co_word(cstate)] <= cdata;
      endcase
    end
  end
endmodule

// File: rtl/preamble_tx.sv
// preamble_tx: sends the configured QPSK preamble one symbol per txstrobe,
// highest symbol first so symbol 0 arrives last.
//   clk, reset : clock, async active-high reset
//   bus        : preamble_tx_if.slave (config, start, txstrobe in;
//                I/Q samples, tx_valid, busy, done, debugbus out)
// debugbus = {clk, busy, done, tx_valid, state, cfg_ignored, idx}
module preamble_tx #(
  parameter int MAX_LEN = preamble_tx_pkg::MAX_LEN
) (
  input  logic         clk,
  input  logic         reset,
  preamble_tx_if.slave bus
);
  import preamble_tx_pkg::*;

  state_t             state;
  logic [8:0]         idx;
  logic               cfg_ignored, busy_r, done_r, tx_valid_r;
  logic [15:0]        r_q, i_q;
  logic [7:0]         co_length;
  logic [14:0]        amp;
  logic [CO_BITS-1:0] co;
  logic [8:0]         len;
  logic               hi, lo;
  logic [15:0]        pos, neg, sym_i, sym_q;

  // Config writes are only taken while idle so a running preamble never
  // changes under the sequencer.
  code_cfg_regs u_cfg (
    .clk       (clk),
    .reset     (reset),
    .we        (bus.cwrite && !busy_r),
    .cstate    (bus.cstate),
    .cdata     (bus.cdata),
    .co_length (co_length),
    .amp       (amp),
    .co        (co)
  );

  always_comb begin
    len   = (int'(co_length) > MAX_LEN) ? 9'(MAX_LEN) : {1'b0, co_length};
    hi    = co[{idx, 1'b1}];
    lo    = co[{idx, 1'b0}];
    pos   = {1'b0, amp};
    neg   = -pos;
    sym_i = hi ? pos : neg;
    sym_q = (hi == lo) ? pos : neg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      r_q         <= '0;
      i_q         <= '0;
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_ignored <= 1'b0;
    end else begin
      tx_valid_r <= 1'b0;
      done_r     <= 1'b0;
      if (bus.cwrite && busy_r) cfg_ignored <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.txstrobe) begin
            r_q <= '0;
            i_q <= '0;
          end
          if (bus.start && !bus.cwrite && len != 9'd0) begin
            state       <= ARMED;
            idx         <= len - 9'd1;
            busy_r      <= 1'b1;
            cfg_ignored <= 1'b0;
          end
        end
        ARMED, SEND: begin
          if (bus.txstrobe) begin
            r_q        <= sym_i;
            i_q        <= sym_q;
            tx_valid_r <= 1'b1;
            if (idx == 9'd0) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              state <= SEND;
              idx   <= idx - 9'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r_output = r_q;
  assign bus.i_output = i_q;
  assign bus.tx_valid = tx_valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.debugbus = {clk, busy_r, done_r, tx_valid_r, state, cfg_ignored, idx};
endmodule

// File: tb/tb_preamble_tx.sv
module tb_preamble_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  preamble_tx_if bus();

  preamble_tx dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the code as a flat bit array plus length and amplitude.
  logic [383:0] m_co;
  int m_len, m_amp;
  bit m_busy;
  int last_i, last_q;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_co = '0; m_len = 192; m_amp = 4096; m_busy = 0; last_i = 0; last_q = 0;
  endtask

  task automatic cfg(input int cs, input logic [31:0] d);
    int w;
    bus.cstate = cs[3:0]; bus.cdata = d; bus.cwrite = 1'b1;
    tick();
    bus.cwrite = 1'b0;
    if (!m_busy) begin
      if (cs == 1) m_len = int'(d[7:0]);
      else if (cs == 2) m_amp = int'(d[14:0]);
      else begin
        w = (cs >= 3 && cs <= 13) ? 14 - cs : 0;
        m_co[w*32 +: 32] = d;
      end
    end
  endtask

  function automatic int eff_len();
    return (m_len > 192) ? 192 : m_len;
  endfunction

  // Gap cycles without a strobe: no tx_valid, outputs held.
  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      tick();
      chk("gap_valid", bus.tx_valid, 0);
      chk("gap_hold_i", $signed(bus.r_output), last_i);
      chk("gap_hold_q", $signed(bus.i_output), last_q);
    end
  endtask

  task automatic strobe_check(input int k);
    bit b1, b0;
    b1 = m_co[2*k+1]; b0 = m_co[2*k];
    last_i = b1 ? m_amp : -m_amp;
    last_q = (b1 == b0) ? m_amp : -m_amp;
    bus.txstrobe = 1'b1;
    tick();
    bus.txstrobe = 1'b0;
    chk("valid", bus.tx_valid, 1);
    chk("sample_i", $signed(bus.r_output), last_i);
    chk("sample_q", $signed(bus.i_output), last_q);
    chk("done", bus.done, (k == 0) ? 1 : 0);
    chk("busy_run", bus.busy, (k != 0) ? 1 : 0);
  endtask

  // Full transmission; a config write of A=50 is attempted before symbol wr_at.
  task automatic send_seq(input int maxgap, input int wr_at);
    int L;
    L = eff_len();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_busy = 1;
    chk("arm_busy", bus.busy, 1);
    chk("arm_idx", bus.debugbus[8:0], L - 1);
    chk("arm_cfgign", bus.debugbus[9], 0);
    for (int k = L - 1; k >= 0; k--) begin
      if (k == wr_at) begin
        cfg(2, 32'd50);
        chk("cfg_ignored_set", bus.debugbus[9], 1);
      end
      gap($urandom_range(0, maxgap));
      strobe_check(k);
    end
    m_busy = 0;
  endtask

  initial begin
    bus.cdata = '0; bus.cstate = '0; bus.cwrite = 1'b0; bus.start = 1'b0; bus.txstrobe = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst_i", $signed(bus.r_output), 0);
    chk("rst_q", $signed(bus.i_output), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfgign", bus.debugbus[9], 0);
    chk("rst_idx", bus.debugbus[8:0], 0);
    reset = 1'b0;
    tick();

    // Strobe while idle: zero outputs, no tx_valid.
    bus.txstrobe = 1'b1; tick(); bus.txstrobe = 1'b0;
    chk("idle_valid", bus.tx_valid, 0);
    chk("idle_i", $signed(bus.r_output), 0);

    // Default config: 192 samples, back-to-back strobes.
    send_seq(0, -1);
    tick();
    chk("dflt_after_busy", bus.busy, 0);
    chk("dflt_after_valid", bus.tx_valid, 0);

    // Directed 4-symbol constellation walk.
    cfg(1, 32'd4); cfg(0, 32'h0000_00E4); cfg(2, 32'd100);
    begin
      int ei[4] = '{100, 100, -100, -100};
      int eq[4] = '{100, -100, -100, 100};
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      for (int s = 0; s < 4; s++) begin
        bus.txstrobe = 1'b1; tick(); bus.txstrobe = 1'b0;
        chk("dir_i", $signed(bus.r_output), ei[s]);
        chk("dir_q", $signed(bus.i_output), eq[s]);
        chk("dir_done", bus.done, (s == 3) ? 1 : 0);
        tick();
      end
      last_i = -100; last_q = 100;
    end

    // Randomized code, amplitude, length and strobe spacing.
    for (int r = 0; r < 3; r++) begin
      for (int cs = 0; cs < 16; cs++) cfg(cs, $urandom());
      cfg(1, $urandom_range(1, 40));
      cfg(2, $urandom());
      send_seq(3, -1);
    end

    // Config write while sending is dropped; a new start clears the flag.
    cfg(1, 32'd8);
    cfg(2, 32'd300);
    send_seq(1, 4);
    chk("cfgign_sticky", bus.debugbus[9], 1);
    cfg(2, 32'd50);
    send_seq(1, -1);
    chk("amp50_i_mag", (last_i < 0) ? -last_i : last_i, 50);

    // Zero length: start ignored.
    cfg(1, 32'd0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("len0_busy", bus.busy, 0);
    bus.txstrobe = 1'b1; tick(); bus.txstrobe = 1'b0;
    chk("len0_valid", bus.tx_valid, 0);
    last_i = 0; last_q = 0;
    // Start coinciding with cwrite: ignored.
    bus.start = 1'b1; cfg(1, 32'd5); bus.start = 1'b0;
    chk("start_cwrite_busy", bus.busy, 0);
    // Over-long length clamps to 192.
    cfg(1, 32'd200);
    send_seq(0, -1);

    // Reset after 10 of 192 samples, then a full run from the top.
    cfg(1, 32'd192);
    for (int cs = 3; cs <= 13; cs++) cfg(cs, $urandom());
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    m_busy = 1;
    for (int k = 191; k > 181; k--) strobe_check(k);
    reset = 1'b1;
    #1;
    chk("abort_i", $signed(bus.r_output), 0);
    chk("abort_q", $signed(bus.i_output), 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    tick();
    chk("abort_done2", bus.done, 0);
    reset = 1'b0;
    model_reset();
    for (int cs = 3; cs <= 13; cs++) cfg(cs, $urandom());
    send_seq(2, -1);

    // Start held high: each acceptance gives exactly one sequence.
    cfg(1, 32'd3);
    cfg(0, $urandom());
    bus.start = 1'b1;
    tick();
    m_busy = 1;
    chk("held_busy1", bus.busy, 1);
    for (int k = 2; k >= 0; k--) strobe_check(k);
    tick();
    chk("held_rearm", bus.busy, 1);
    chk("held_idx", bus.debugbus[8:0], 2);
    for (int k = 2; k >= 0; k--) strobe_check(k);
    bus.start = 1'b0;
    tick();
    chk("held_end_busy", bus.busy, 0);
    chk("held_end_valid", bus.tx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
